// File: rtl/wb_regfile_writer_if.sv
// Purpose : bundles the WB-stage writeback bus, the two ID-stage read ports and
//           the GTE coprocessor valid/ready write channel into one port group.
// Ports   : WB_* writeback bundle in, WB_WriteData/WB_GteStall out;
//           ID_Rs/ID_Rt in, ID_ReadData1/2 out; GTE_Valid/Addr/Data out, GTE_Ready in.
// Modports: slave = the register-file writer; master = the pipeline/GTE side driving it.
interface wb_regfile_writer_if #(
  parameter int ADDR_WIDTH = 5
);
  // WB-stage bundle from the MEM/WB pipeline register
  logic                  WB_RegWrite;
  logic                  WB_MemtoReg;
  logic [31:0]           WB_ReadData;
  logic [31:0]           WB_ALU_Result;
  logic [ADDR_WIDTH-1:0] WB_RtRd;
  logic                  WB_Gte;

  // Writeback results back toward the pipeline
  logic [31:0]           WB_WriteData;
  logic                  WB_GteStall;

  // ID-stage read ports
  logic [ADDR_WIDTH-1:0] ID_Rs;
  logic [ADDR_WIDTH-1:0] ID_Rt;
  logic [31:0]           ID_ReadData1;
  logic [31:0]           ID_ReadData2;

  // GTE coprocessor write channel
  logic                  GTE_Valid;
  logic                  GTE_Ready;
  logic [ADDR_WIDTH-1:0] GTE_Addr;
  logic [31:0]           GTE_Data;

  modport slave (
    input  WB_RegWrite, WB_MemtoReg, WB_ReadData, WB_ALU_Result, WB_RtRd, WB_Gte,
    input  ID_Rs, ID_Rt,
    input  GTE_Ready,
    output WB_WriteData, WB_GteStall,
    output ID_ReadData1, ID_ReadData2,
    output GTE_Valid, GTE_Addr, GTE_Data
  );

  modport master (
    output WB_RegWrite, WB_MemtoReg, WB_ReadData, WB_ALU_Result, WB_RtRd, WB_Gte,
    output ID_Rs, ID_Rt,
    output GTE_Ready,
    input  WB_WriteData, WB_GteStall,
    input  ID_ReadData1, ID_ReadData2,
    input  GTE_Valid, GTE_Addr, GTE_Data
  );
endinterface

// File: rtl/wb_regfile_writer.sv
// Purpose : WB-stage sink; selects the writeback value, commits it to the GPR file
//           (r0 hardwired to zero) and forwards GTE-flagged writes through a one-entry buffer.
// Latency : WB_WriteData, ID reads and WB_GteStall are combinational; GPR write and
//           GTE capture take effect at the next rising clock edge.
// Backpressure: the GTE buffer holds its request until GTE_Ready; a new GTE write arriving
//           while the buffer is full and unaccepted raises WB_GteStall so upstream holds it.
// Ports   : clock, reset (synchronous, active-high); bus = wb_regfile_writer_if.slave
//           carrying the WB bundle, ID read ports and GTE valid/ready channel.
// Config  : define WB_BYPASS_EN to let ID reads see a GPR being written in the same cycle;
//           without it reads return the pre-edge contents.
module wb_regfile_writer #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic               clock,
  input  logic               reset,
  wb_regfile_writer_if.slave bus
);

  // The index must exactly cover the register file.
  if (NUM_REGS != (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("wb_regfile_writer: NUM_REGS must equal 2**ADDR_WIDTH");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } gte_state_t;

  // ------------------------------------------------------------------
  // Writeback value selection and write decode
  // ------------------------------------------------------------------
  logic [31:0] wb_write_data;
  logic        gpr_we;
  logic        gte_req;

  assign wb_write_data = bus.WB_MemtoReg ? bus.WB_ReadData : bus.WB_ALU_Result;

  // Writes to r0 are dropped here so the array entry stays zero after reset.
  assign gpr_we  = bus.WB_RegWrite & ~bus.WB_Gte & (bus.WB_RtRd != '0);
  assign gte_req = bus.WB_RegWrite &  bus.WB_Gte;

  // ------------------------------------------------------------------
  // GPR file
  // ------------------------------------------------------------------
  logic [31:0] regs [NUM_REGS];

  // Not gated by the GTE stall: a held non-GTE write simply rewrites the same value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (gpr_we) begin
      regs[bus.WB_RtRd] <= wb_write_data;
    end
  end

  logic [31:0] rd_data1;
  logic [31:0] rd_data2;

  always_comb begin
    rd_data1 = (bus.ID_Rs == '0) ? '0 : regs[bus.ID_Rs];
    rd_data2 = (bus.ID_Rt == '0) ? '0 : regs[bus.ID_Rt];
`ifdef WB_BYPASS_EN
    // gpr_we already excludes r0, so the zero-register rule still holds.
    if (gpr_we && (bus.ID_Rs == bus.WB_RtRd)) begin
      rd_data1 = wb_write_data;
    end
    if (gpr_we && (bus.ID_Rt == bus.WB_RtRd)) begin
      rd_data2 = wb_write_data;
    end
`else
    // Pre-edge contents only; WB-to-ID hazards are resolved by the hazard unit.
`endif
  end

  // ------------------------------------------------------------------
  // GTE one-entry buffer
  // ------------------------------------------------------------------
  gte_state_t            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] gte_addr_q, gte_addr_d;
  logic [31:0]           gte_data_q, gte_data_d;
  logic                  gte_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      // A pending request is dropped without a handshake.
      state_q    <= S_IDLE;
      gte_addr_q <= '0;
      gte_data_q <= '0;
    end else begin
      state_q    <= state_d;
      gte_addr_q <= gte_addr_d;
      gte_data_q <= gte_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gte_addr_d = gte_addr_q;
    gte_data_d = gte_data_q;
    gte_stall  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (gte_req) begin
          gte_addr_d = bus.WB_RtRd;
          gte_data_d = wb_write_data;
          state_d    = S_PEND;
        end
      end
      S_PEND: begin
        if (bus.GTE_Ready) begin
          if (gte_req) begin
            // Slot frees this edge and refills immediately: no bubble.
            gte_addr_d = bus.WB_RtRd;
            gte_data_d = wb_write_data;
          end else begin
            state_d = S_IDLE;
          end
        end else if (gte_req) begin
          // Buffer full and not draining; upstream re-presents the request.
          gte_stall = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.WB_WriteData = wb_write_data;
  assign bus.WB_GteStall  = gte_stall;
  assign bus.ID_ReadData1 = rd_data1;
  assign bus.ID_ReadData2 = rd_data2;

  // Valid is pure registered state, never a combinational function of GTE_Ready.
  assign bus.GTE_Valid = (state_q == S_PEND);
  assign bus.GTE_Addr  = gte_addr_q;
  assign bus.GTE_Data  = gte_data_q;

  // A request that is offered but not taken must stay put.
  a_gte_hold : assert property (
    @(posedge clock) disable iff (reset)
      ((state_q == S_PEND) && !bus.GTE_Ready)
        |=> ((state_q == S_PEND) && $stable(gte_addr_q) && $stable(gte_data_q))
  );

endmodule

// File: tb/tb_wb_regfile_writer.sv
module tb_wb_regfile_writer;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  wb_regfile_writer_if #(.ADDR_WIDTH(5)) bus ();

  wb_regfile_writer #(
    .NUM_REGS  (32),
    .ADDR_WIDTH(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------------
  // Reference model: architectural register array plus a single GTE slot
  // and an ordered list of GTE writes still owed to the coprocessor.
  // ------------------------------------------------------------------
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } gte_xfer_t;

  logic [31:0] m_regs [32];
  bit          m_valid = 1'b0;
  bit          m_pend  = 1'b0;
  logic [4:0]  m_addr  = '0;
  logic [31:0] m_data  = '0;
  gte_xfer_t   m_q [$];

  function automatic logic [31:0] m_wdata();
    return bus.WB_MemtoReg ? bus.WB_ReadData : bus.WB_ALU_Result;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (bus.WB_RegWrite && !bus.WB_Gte && bus.WB_RtRd != 5'd0 && idx == bus.WB_RtRd)
      return m_wdata();
`endif
    return m_regs[idx];
  endfunction

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_step();
    gte_xfer_t x;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_pend  = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_q.delete();
      m_valid = 1'b1;
    end else begin
      if (bus.WB_RegWrite && !bus.WB_Gte && bus.WB_RtRd != 5'd0)
        m_regs[bus.WB_RtRd] = m_wdata();
      if (m_pend && bus.GTE_Ready) begin
        if (m_q.size() == 0) begin
          check("gte_xfer_unexpected", 32'(bus.GTE_Addr), 32'hFFFF_FFFF);
        end else begin
          x = m_q.pop_front();
          check("gte_xfer_addr", 32'(bus.GTE_Addr), 32'(x.addr));
          check("gte_xfer_data", bus.GTE_Data, x.data);
        end
        m_pend = 1'b0;
      end
      if (bus.WB_RegWrite && bus.WB_Gte && !m_pend) begin
        m_pend = 1'b1;
        m_addr = bus.WB_RtRd;
        m_data = m_wdata();
        x.addr = m_addr;
        x.data = m_data;
        m_q.push_back(x);
      end
    end
  endtask

  // Compare process: outputs checked mid-cycle, then the model advances.
  always @(negedge clock) begin
    if (m_valid) begin
      check("wb_write_data", bus.WB_WriteData, m_wdata());
      check("id_read_data1", bus.ID_ReadData1, m_read(bus.ID_Rs));
      check("id_read_data2", bus.ID_ReadData2, m_read(bus.ID_Rt));
      check("gte_valid", 32'(bus.GTE_Valid), 32'(m_pend));
      check("gte_stall", 32'(bus.WB_GteStall),
            32'(m_pend && !bus.GTE_Ready && bus.WB_RegWrite && bus.WB_Gte));
      check("gte_addr", 32'(bus.GTE_Addr), 32'(m_addr));
      check("gte_data", bus.GTE_Data, m_data);
    end
    model_step();
  end

  // ------------------------------------------------------------------
  // Directed stimulus with hand-computed literal expectations
  // ------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wb_idle();
    bus.WB_RegWrite   = 1'b0;
    bus.WB_MemtoReg   = 1'b0;
    bus.WB_ReadData   = 32'h0;
    bus.WB_ALU_Result = 32'h0;
    bus.WB_RtRd       = 5'd0;
    bus.WB_Gte        = 1'b0;
  endtask

  task automatic wb_write(input logic gte, input logic m2r, input logic [31:0] rdata,
                          input logic [31:0] alu, input logic [4:0] rd);
    bus.WB_RegWrite   = 1'b1;
    bus.WB_Gte        = gte;
    bus.WB_MemtoReg   = m2r;
    bus.WB_ReadData   = rdata;
    bus.WB_ALU_Result = alu;
    bus.WB_RtRd       = rd;
  endtask

  logic [31:0] r7_expect;

  initial begin
    reset         = 1'b1;
    wb_idle();
    bus.ID_Rs     = 5'd0;
    bus.ID_Rt     = 5'd0;
    bus.GTE_Ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state: every index reads zero, GTE side quiet.
    #1;
    check("lit_reset_gte_valid", 32'(bus.GTE_Valid), 32'h0);
    check("lit_reset_gte_stall", 32'(bus.WB_GteStall), 32'h0);
    for (int i = 0; i < 32; i++) begin
      bus.ID_Rs = 5'(i);
      bus.ID_Rt = 5'(31 - i);
      #1;
      check("lit_reset_rd1", bus.ID_ReadData1, 32'h0);
      check("lit_reset_rd2", bus.ID_ReadData2, 32'h0);
      step();
    end

    // ALU-result writeback to r5.
    wb_write(1'b0, 1'b0, 32'h0BAD_F00D, 32'h1234_5678, 5'd5);
    #1 check("lit_wdata_alu", bus.WB_WriteData, 32'h1234_5678);
    step();
    wb_idle();
    bus.ID_Rs = 5'd5;
    #1 check("lit_r5", bus.ID_ReadData1, 32'h1234_5678);
    step();

    // Load-data writeback to r31.
    wb_write(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0055, 5'd31);
    #1 check("lit_wdata_mem", bus.WB_WriteData, 32'hDEAD_BEEF);
    step();
    wb_idle();
    bus.ID_Rs = 5'd31;
    #1 check("lit_r31", bus.ID_ReadData1, 32'hDEAD_BEEF);
    step();

    // r0 ignores writes, even with a same-cycle read.
    wb_write(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
    bus.ID_Rs = 5'd0;
    #1 check("lit_r0_during_write", bus.ID_ReadData1, 32'h0);
    step();
    wb_idle();
    #1 check("lit_r0_after_write", bus.ID_ReadData1, 32'h0);
    step();

    // Same-cycle write/read of r7.
    wb_write(1'b0, 1'b0, 32'h0, 32'h1111_1111, 5'd7);
    step();
    wb_write(1'b0, 1'b0, 32'h0, 32'hA5A5_A5A5, 5'd7);
    bus.ID_Rt = 5'd7;
`ifdef WB_BYPASS_EN
    r7_expect = 32'hA5A5_A5A5;
`else
    r7_expect = 32'h1111_1111;
`endif
    #1 check("lit_r7_same_cycle", bus.ID_ReadData2, r7_expect);
    step();
    wb_idle();
    #1 check("lit_r7_next_cycle", bus.ID_ReadData2, 32'hA5A5_A5A5);

    // Give r3 a GPR value that GTE writes to index 3 must not touch.
    wb_write(1'b0, 1'b0, 32'h0, 32'h3333_3333, 5'd3);
    step();

    // GTE write held off by the coprocessor, second write stalls.
    bus.GTE_Ready = 1'b0;
    wb_write(1'b1, 1'b0, 32'h0, 32'h0000_0100, 5'd3);
    bus.ID_Rs = 5'd3;
    #1;
    check("lit_gte_valid_idle", 32'(bus.GTE_Valid), 32'h0);
    check("lit_gte_stall_idle", 32'(bus.WB_GteStall), 32'h0);
    step();
    wb_write(1'b1, 1'b0, 32'h0, 32'h0000_0200, 5'd4);
    #1;
    check("lit_gte_valid_pend", 32'(bus.GTE_Valid), 32'h1);
    check("lit_gte_addr_pend", 32'(bus.GTE_Addr), 32'h3);
    check("lit_gte_data_pend", bus.GTE_Data, 32'h0000_0100);
    check("lit_gte_stall_full", 32'(bus.WB_GteStall), 32'h1);
    step();
    #1;
    check("lit_gte_addr_held", 32'(bus.GTE_Addr), 32'h3);
    check("lit_gte_data_held", bus.GTE_Data, 32'h0000_0100);
    check("lit_gte_stall_held", 32'(bus.WB_GteStall), 32'h1);
    check("lit_r3_during_gte", bus.ID_ReadData1, 32'h3333_3333);
    bus.GTE_Ready = 1'b1;
    #1 check("lit_gte_stall_drop", 32'(bus.WB_GteStall), 32'h0);
    step();
    wb_idle();
    bus.GTE_Ready = 1'b0;
    #1;
    check("lit_gte_valid_b2b", 32'(bus.GTE_Valid), 32'h1);
    check("lit_gte_addr_b2b", 32'(bus.GTE_Addr), 32'h4);
    check("lit_gte_data_b2b", bus.GTE_Data, 32'h0000_0200);
    check("lit_r3_after_gte", bus.ID_ReadData1, 32'h3333_3333);
    step();

    // Reset while a GTE write is pending drops it and clears the GPRs.
    reset = 1'b1;
    step();
    #1;
    check("lit_rst_gte_valid", 32'(bus.GTE_Valid), 32'h0);
    check("lit_rst_gte_addr", 32'(bus.GTE_Addr), 32'h0);
    check("lit_rst_gte_data", bus.GTE_Data, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.ID_Rs = 5'(i);
      bus.ID_Rt = 5'(i ^ 5'h1F);
      #1;
      check("lit_rst_rd1", bus.ID_ReadData1, 32'h0);
      check("lit_rst_rd2", bus.ID_ReadData2, 32'h0);
      step();
    end

    // Pending write accepted with no follow-up request: buffer empties.
    wb_write(1'b1, 1'b1, 32'h0000_0999, 32'h0, 5'd9);
    step();
    wb_idle();
    bus.GTE_Ready = 1'b1;
    #1 check("lit_gte_addr_r9", 32'(bus.GTE_Addr), 32'h9);
    step();
    bus.GTE_Ready = 1'b0;
    #1 check("lit_gte_valid_drained", 32'(bus.GTE_Valid), 32'h0);
    step();

    // Streaming GTE writes with the coprocessor always ready.
    bus.GTE_Ready = 1'b1;
    wb_write(1'b1, 1'b0, 32'h0, 32'h0000_000A, 5'd10);
    step();
    wb_write(1'b1, 1'b0, 32'h0, 32'h0000_000B, 5'd11);
    #1;
    check("lit_stream_addr10", 32'(bus.GTE_Addr), 32'hA);
    check("lit_stream_nostall", 32'(bus.WB_GteStall), 32'h0);
    step();
    wb_idle();
    #1;
    check("lit_stream_addr11", 32'(bus.GTE_Addr), 32'hB);
    check("lit_stream_data11", bus.GTE_Data, 32'h0000_000B);
    check("lit_stream_valid", 32'(bus.GTE_Valid), 32'h1);
    step();
    #1 check("lit_stream_done", 32'(bus.GTE_Valid), 32'h0);
    bus.GTE_Ready = 1'b0;
    repeat (2) step();

    if (m_q.size() != 0) check("gte_xfer_outstanding", 32'(m_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_regfile_writer.md
Name: wb_regfile_writer

Overview:
- Consumer end of the MEM/WB pipeline register; sinks the WB-stage bundle (RegWrite, MemtoReg, ReadData, ALU_Result, RtRd, Gte).
- Selects the writeback value and commits it to the 32x32 GPR file.
- Routes GTE-flagged writes to the GTE coprocessor through a one-entry valid/ready buffer.
- Provides two ID-stage read ports and a WB forwarding value; raises a stall when the GTE buffer cannot accept a write.

Parameters:
- NUM_REGS, 32, number of GPRs; index 0 hardwired to zero.
- ADDR_WIDTH, 5, register index width; must satisfy 2^ADDR_WIDTH == NUM_REGS.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- WB_RegWrite  in  1  writeback enable.
- WB_MemtoReg  in  1  1 = write WB_ReadData; 0 = write WB_ALU_Result.
- WB_ReadData  in  32  load data.
- WB_ALU_Result  in  32  ALU result.
- WB_RtRd  in  5  destination index.
- WB_Gte  in  1  1 = destination is a GTE register, not a GPR.
- ID_Rs  in  5  read port A index.
- ID_Rt  in  5  read port B index.
- ID_ReadData1  out  32  port A data.
- ID_ReadData2  out  32  port B data.
- WB_WriteData  out  32  selected writeback value, for forwarding.
- WB_GteStall  out  1  pipeline stall request; feeds WB_Stall and M_Stall logic.
- GTE_Valid  out  1  GTE write request valid.
- GTE_Ready  in  1  GTE accepts the request.
- GTE_Addr  out  5  GTE register index.
- GTE_Data  out  32  GTE write data.

Behaviour:
- Clock and reset: single clock domain on clock; reset is synchronous and active-high, sampled at the rising edge of clock.
- Write data selection: WB_WriteData = WB_MemtoReg ? WB_ReadData : WB_ALU_Result. Combinational, zero latency.
- GPR write: at the clock edge when WB_RegWrite & ~WB_Gte & (WB_RtRd != 0), regs[WB_RtRd] <= WB_WriteData. Writes to index 0 are discarded.
- GPR reads: ID_ReadDataN = (index == 0) ? 0 : regs[index]. Combinational, asynchronous read.
- GTE buffer FSM has two states, IDLE and PEND:
  - gte_req = WB_RegWrite & WB_Gte.
  - IDLE, gte_req: capture GTE_Addr <= WB_RtRd and GTE_Data <= WB_WriteData; go to PEND.
  - PEND: GTE_Valid = 1; GTE_Addr and GTE_Data hold stable until the handshake completes.
  - PEND, GTE_Ready & ~gte_req: go to IDLE.
  - PEND, GTE_Ready & gte_req: capture the new request, stay in PEND (back-to-back transfer, no bubble).
  - PEND, ~GTE_Ready & gte_req: WB_GteStall = 1 (combinational), no capture, stay in PEND. The upstream stall holds the WB bundle, so the request is re-presented next cycle.
- WB_GteStall = (state == PEND) & ~GTE_Ready & gte_req; 0 in every other case.
- GPR writes are not gated by WB_GteStall. A held non-GTE write rewrites the same value, which is idempotent.
- GTE_Valid is registered state (state == PEND) only. It never depends combinationally on GTE_Ready.
- Reset values: all regs = 0; state = IDLE; GTE_Valid = 0; GTE_Addr = 0; GTE_Data = 0. Combinational outputs follow their inputs.
- Reset mid-transfer: a pending GTE write is dropped without handshake. The GTE side must tolerate this.
- Same-cycle write and read of the same GPR: see Optional Feature.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: if WB_RegWrite & ~WB_Gte & (WB_RtRd != 0) & (ID_Rs == WB_RtRd), then ID_ReadData1 = WB_WriteData. Same rule for ID_Rt / ID_ReadData2. ID sees the value being written this cycle.
- Not defined: reads return the pre-edge register contents. The hazard unit must forward or stall for WB-to-ID dependencies.

Test Plan:
- Reset, then read every index -> all 0; GTE_Valid = 0; WB_GteStall = 0.
- RegWrite=1, MemtoReg=0, ALU_Result=0x12345678, RtRd=5; next cycle ID_Rs=5 -> ID_ReadData1 = 0x12345678. Same with MemtoReg=1, ReadData=0xDEADBEEF, RtRd=31 -> 0xDEADBEEF.
- Write 0xFFFFFFFF to RtRd=0; read Rs=0 -> 0.
- With WB_BYPASS_EN: write 0xA5A5A5A5 to r7 while ID_Rt=7 in the same cycle -> ID_ReadData2 = 0xA5A5A5A5 combinationally. Without the macro -> old r7 value.
- Gte=1, RtRd=3, ALU_Result=0x100, GTE_Ready=0 -> next cycle GTE_Valid=1, GTE_Addr=3, GTE_Data=0x100. Then a second GTE write (RtRd=4) -> WB_GteStall=1, outputs unchanged. Raise GTE_Ready -> stall drops; next cycle GTE_Addr=4, GTE_Valid stays 1. GPR r3 unchanged throughout.
- Assert reset while in PEND -> next cycle GTE_Valid=0 and all GPRs = 0.
